// File: rtl/sha2_msg_padder_pkg.sv
// rtl/sha2_msg_padder_pkg.sv - shared constants and state type for the SHA-256 single-chunk padder
//
// Holds the block geometry, the padding marker byte, the one-chunk length
// limit and the padder FSM state encoding.

package sha2_msg_padder_pkg;

  localparam int          SHA2_BLOCK_W          = 512;
  localparam int          SHA2_LEN_W            = 64;
  localparam int          SHA2_MAX_1CHUNK_BYTES = 55;
  localparam logic [7:0]  SHA2_PAD_BYTE         = 8'h80;

  localparam int          SHA2_BLOCK_BYTES      = SHA2_BLOCK_W / 8;
  // Bytes in front of the length field: message, 0x80 marker and zero fill.
  localparam int          SHA2_DATA_BYTES       = SHA2_BLOCK_BYTES - SHA2_LEN_W / 8;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_PAD     = 2'd2,
    ST_HOLD    = 2'd3
  } pad_state_e;

endpackage

// File: rtl/sha2_msg_padder.sv
// rtl/sha2_msg_padder.sv - packs a short byte message into one padded 512-bit SHA-256 chunk
//
// Ports:
//   clock      - single clock, all state on the rising edge
//   reset      - synchronous, active-high
//   in_valid   - in_data/in_bytes/in_last valid this cycle
//   in_ready   - padder accepts a word this cycle (registered)
//   in_data    - 32-bit message word, first byte in 31:24
//   in_bytes   - left-aligned valid byte count (4 unless in_last)
//   in_last    - this word ends the message
//   out_block  - padded chunk, message byte 0 in 511:504 (registered)
//   out_valid  - out_block valid and held stable
//   out_ready  - downstream takes out_block
//   err        - one-cycle pulse on an over-long message or bad in_bytes

module sha2_msg_padder
  import sha2_msg_padder_pkg::*;
#(
  parameter int MAX_BYTES = SHA2_MAX_1CHUNK_BYTES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  input  logic [2:0]              in_bytes,
  input  logic                    in_last,
  output logic [SHA2_BLOCK_W-1:0] out_block,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err
);

  localparam logic [6:0] MAX_BYTES_W = 7'(MAX_BYTES);

  pad_state_e              state_q, state_d;
  logic [5:0]              byte_cnt_q, byte_cnt_d;
  logic [SHA2_BLOCK_W-1:0] block_q, block_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    err_q, err_d;

  logic       xfer;
  logic [6:0] cnt_sum;
  logic       bad_bytes;
  logic       too_long;
  logic       collect_err;

  assign xfer        = in_valid && in_ready_q;
  assign cnt_sum     = {1'b0, byte_cnt_q} + {4'b0000, in_bytes};
  // Only the final word may be short; more than 4 bytes is never legal.
  assign bad_bytes   = (in_bytes > 3'd4) || (!in_last && (in_bytes != 3'd4));
  assign too_long    = cnt_sum > MAX_BYTES_W;
  assign collect_err = bad_bytes || too_long;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (xfer) begin
          if (collect_err) begin
            // A faulty last word ends the message on the spot; otherwise
            // the rest of the message still has to be swallowed.
            state_d = in_last ? ST_COLLECT : ST_DRAIN;
          end else if (in_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer && in_last) begin
          state_d = ST_COLLECT;
        end
      end
      ST_PAD: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // Outputs are registered from the next state so that in_ready/out_valid
  // never depend combinationally on inputs.
  always_comb begin
    in_ready_d  = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
    out_valid_d = (state_d == ST_HOLD);
  end

  // Datapath: block assembly, padding and error pulse
  always_comb begin
    block_d    = block_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (xfer) begin
          if (collect_err) begin
            err_d = 1'b1;
            if (in_last) begin
              block_d    = '0;
              byte_cnt_d = '0;
            end
          end else begin
            // Byte-enable decode: lane i takes input byte k when it sits
            // at offset byte_cnt+k and k is within in_bytes.
            for (int i = 0; i < SHA2_DATA_BYTES; i++) begin
              for (int k = 0; k < 4; k++) begin
                if ((k < int'(in_bytes)) && ((int'(byte_cnt_q) + k) == i)) begin
                  block_d[SHA2_BLOCK_W-1-8*i -: 8] = in_data[31-8*k -: 8];
                end
              end
            end
            byte_cnt_d = cnt_sum[5:0];
          end
        end
      end
      ST_DRAIN: begin
        if (xfer && in_last) begin
          block_d    = '0;
          byte_cnt_d = '0;
        end
      end
      ST_PAD: begin
        for (int i = 0; i < SHA2_DATA_BYTES; i++) begin
          if (i == int'(byte_cnt_q)) begin
            block_d[SHA2_BLOCK_W-1-8*i -: 8] = SHA2_PAD_BYTE;
          end else if (i > int'(byte_cnt_q)) begin
            block_d[SHA2_BLOCK_W-1-8*i -: 8] = 8'h00;
          end
        end
        block_d[SHA2_LEN_W-1:0] = SHA2_LEN_W'({byte_cnt_q, 3'b000});
      end
      ST_HOLD: begin
        if (out_ready) begin
          block_d    = '0;
          byte_cnt_d = '0;
        end
      end
      default: begin
        block_d    = '0;
        byte_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      block_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      block_q     <= block_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = block_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sha2_msg_padder.sv
// tb/tb_sha2_msg_padder.sv - directed self-checking bench for sha2_msg_padder

module tb_sha2_msg_padder;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic [511:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int ov_cycles = 0;

  sha2_msg_padder #(.MAX_BYTES(55)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (err) err_seen <= err_seen + 1;
    if (out_valid) ov_cycles <= ov_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one word and returns #1 after the edge on which it transferred.
  task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = b;
    in_last  = l;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check_eq("send_timeout", 0, 1);
    end else begin
      step();
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_bytes = 3'd0;
    in_last  = 1'b0;
  endtask

  // Called #1 after the last word's transfer: checks PAD latency, the block,
  // then accepts it and checks the padder is ready again.
  task automatic expect_block(input string tag, input logic [511:0] exp);
    check_eq({tag, "_pad_cycle_out_valid"}, out_valid, 0);
    step();
    check_eq({tag, "_out_valid"}, out_valid, 1);
    check_eq({tag, "_block"}, out_block, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_in_ready_after"}, in_ready, 1);
    check_eq({tag, "_out_valid_after"}, out_valid, 0);
  endtask

  task automatic run_abc(input string tag);
    int e0;
    e0 = err_seen;
    send_word(32'h61626300, 3'd3, 1'b1);
    expect_block(tag, {32'h61626380, 416'h0, 64'h18});
    check_eq({tag, "_no_err"}, err_seen - e0, 0);
  endtask

  initial begin
    logic [511:0] exp;
    logic [511:0] held;
    int e0;
    int ov0;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_bytes  = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_out_block", out_block, 0);

    reset = 1'b0;
    step();
    check_eq("in_ready_after_reset", in_ready, 1);

    // "abc"
    run_abc("abc");

    // Empty message; garbage bytes beyond in_bytes ignored
    send_word(32'hDEADBEEF, 3'd0, 1'b1);
    expect_block("empty", {8'h80, 440'h0, 64'h0});

    // 55 bytes 0x00..0x36, last word carries junk in its unused byte
    e0 = err_seen;
    for (int w = 0; w < 13; w++) begin
      send_word({8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)}, 3'd4, 1'b0);
    end
    send_word(32'h343536AA, 3'd3, 1'b1);
    exp = '0;
    for (int i = 0; i < 55; i++) exp[511-8*i -: 8] = 8'(i);
    exp[71:64] = 8'h80;
    exp[63:0]  = 64'h1B8;
    expect_block("max55", exp);
    check_eq("max55_no_err", err_seen - e0, 0);

    // Backpressure in HOLD
    send_word(32'h68695A5A, 3'd2, 1'b1);
    step();
    check_eq("bp_out_valid", out_valid, 1);
    check_eq("bp_block", out_block, {8'h68, 8'h69, 8'h80, 424'h0, 64'h10});
    held = out_block;
    for (int c = 0; c < 10; c++) begin
      step();
      check_eq("bp_stable", out_block, held);
      check_eq("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_in_ready_after", in_ready, 1);

    // 56 bytes: too long, err once, no output, then recovers
    e0  = err_seen;
    ov0 = ov_cycles;
    for (int w = 0; w < 13; w++) send_word(32'h01020304, 3'd4, 1'b0);
    send_word(32'h05060708, 3'd4, 1'b1);
    check_eq("len56_err_pulse", err, 1);
    step();
    check_eq("len56_err_drop", err, 0);
    repeat (4) step();
    check_eq("len56_err_count", err_seen - e0, 1);
    check_eq("len56_no_out_valid", ov_cycles - ov0, 0);
    check_eq("len56_in_ready", in_ready, 1);
    run_abc("after56");

    // Short non-last word: err, remainder drained silently
    e0  = err_seen;
    ov0 = ov_cycles;
    send_word(32'h11223344, 3'd4, 1'b0);
    send_word(32'h55667788, 3'd2, 1'b0);
    check_eq("short_err_pulse", err, 1);
    send_word(32'h99AABBCC, 3'd4, 1'b0);
    send_word(32'hDDEEFF00, 3'd4, 1'b1);
    repeat (3) step();
    check_eq("short_err_count", err_seen - e0, 1);
    check_eq("short_no_out_valid", ov_cycles - ov0, 0);
    run_abc("after_drain");

    // in_bytes=5 on a last word
    e0  = err_seen;
    ov0 = ov_cycles;
    send_word(32'h61626364, 3'd5, 1'b1);
    repeat (3) step();
    check_eq("bytes5_err_count", err_seen - e0, 1);
    check_eq("bytes5_no_out_valid", ov_cycles - ov0, 0);
    run_abc("after_bytes5");

    // Reset mid-message drops it without err
    e0 = err_seen;
    send_word(32'h41424344, 3'd4, 1'b0);
    send_word(32'h45464748, 3'd4, 1'b0);
    reset = 1'b1;
    step();
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_err", err, 0);
    check_eq("mid_rst_out_block", out_block, 0);
    reset = 1'b0;
    step();
    check_eq("mid_rst_in_ready_after", in_ready, 1);
    check_eq("mid_rst_no_err", err_seen - e0, 0);
    run_abc("after_mid_rst");

    // Reset while holding a block
    send_word(32'h61626300, 3'd3, 1'b1);
    repeat (2) step();
    reset = 1'b1;
    step();
    check_eq("hold_rst_out_valid", out_valid, 0);
    check_eq("hold_rst_out_block", out_block, 0);
    reset = 1'b0;
    step();
    run_abc("after_hold_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha2_msg_padder.md
SHA2_MSG_PADDER -- requirements
Module: sha2_msg_padder

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 55, meaning the largest message length in bytes that fits one 512-bit SHA-256 chunk.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  in_data/in_bytes/in_last are valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts an input word this cycle.
REQ-006 SHALL have port in_data  input  32  message word; first byte in bits 31:24.
REQ-007 SHALL have port in_bytes  input  3  valid bytes in in_data: 4 when in_last=0; 0..4 when in_last=1; valid bytes are left-aligned.
REQ-008 SHALL have port in_last  input  1  this word ends the message.
REQ-009 SHALL have port out_block  output  512  padded chunk; message byte 0 in bits 511:504.
REQ-010 SHALL have port out_valid  output  1  out_block is valid and held stable.
REQ-011 SHALL have port out_ready  input  1  the downstream hash wrapper takes out_block.
REQ-012 SHALL have port err  output  1  one-cycle pulse on a message that is too long or has a bad in_bytes value.

Function
REQ-013 SHALL use 4 states: COLLECT, DRAIN, PAD, HOLD.
REQ-014 A transfer SHALL occur when in_valid and in_ready are both high; in_ready SHALL be high only in COLLECT and DRAIN.
REQ-015 In COLLECT, each transfer SHALL write its in_bytes bytes to the block at byte offset byte_cnt, and byte_cnt (6-bit) SHALL advance by in_bytes.
REQ-016 In COLLECT, a transfer with in_last=0 and in_bytes!=4 SHALL pulse err and go to DRAIN.
REQ-017 In COLLECT, a transfer with in_bytes>4 SHALL pulse err, and SHALL go to DRAIN when in_last=0 or to COLLECT with all state cleared when in_last=1.
REQ-018 In COLLECT, a transfer that makes byte_cnt+in_bytes exceed MAX_BYTES SHALL pulse err the next cycle, and SHALL go to DRAIN when in_last=0 or to COLLECT with all state cleared when in_last=1.
REQ-019 Otherwise, a valid transfer with in_last=1 SHALL go to PAD.
REQ-020 DRAIN SHALL discard words and return to COLLECT with all state cleared after the word with in_last=1; it SHALL raise no further err.
REQ-021 PAD SHALL last exactly one cycle and SHALL write 0x80 at byte offset L (L = total message bytes), zero bytes L+1..55, and L*8 as a 64-bit big-endian value in bits 63:0; then go to HOLD.
REQ-022 In HOLD, out_valid SHALL be 1 and out_block SHALL stay constant; when out_ready=1, the block SHALL clear block and byte_cnt and return to COLLECT the next cycle.
REQ-023 Latency: out_valid SHALL rise exactly 2 cycles after the cycle in which the in_last word transfers.
REQ-024 A zero-length message (a single word with in_last=1 and in_bytes=0) SHALL produce 0x80 followed by zeros, with the length field 0.
REQ-025 When L=MAX_BYTES, 0x80 SHALL occupy byte 55 and there SHALL be no zero-fill between 0x80 and the length field.
REQ-026 Bytes in in_data beyond in_bytes SHALL be ignored.
REQ-027 out_block outside HOLD SHALL be don't-care, and the downstream block SHALL sample it only while out_valid=1.

Reset
REQ-028 While reset=1: state SHALL be COLLECT, byte_cnt 0, internal block all-zero, in_ready 0, out_valid 0, err 0, out_block 0.
REQ-029 in_ready SHALL go to 1 on the first cycle after reset deasserts.
REQ-030 Reset SHALL take priority over every transfer and state, including mid-message, PAD and HOLD; a partial message SHALL be dropped without err.

Structure
REQ-031 A shared package SHALL hold: SHA2_BLOCK_W=512, SHA2_LEN_W=64, SHA2_MAX_1CHUNK_BYTES=55, SHA2_PAD_BYTE=8'h80, and the padder state enum.
REQ-032 The block SHALL have no sub-module; byte-lane writes SHALL use a byte-enable decode on byte_cnt inside the block.
REQ-033 out_block SHALL come directly from a register, with no combinational path from inputs to outputs except in_ready depending on state.

Verification
REQ-034 "abc": word 0x61626300, in_bytes=3, in_last=1 -> out_block = 0x6162638000…0018, and out_valid rises 2 cycles after the transfer.
REQ-035 Empty message (in_bytes=0, in_last=1) -> out_block = 0x80 followed by 440 zero bits and a length field of 0x0000000000000000.
REQ-036 55 bytes 0x00..0x36 (13 full words plus 3 bytes) -> byte 55 = 0x80, bits 63:0 = 0x1B8, no err.
REQ-037 56 bytes in 14 full words, last word with in_last=1 -> err pulses once, out_valid never rises, next message "abc" pads correctly.
REQ-038 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_block stable, in_ready=0; the cycle after out_ready=1 -> in_ready=1.
REQ-039 Reset asserted after 2 words of a message -> all outputs 0 during reset; a following "abc" gives the REQ-034 result.
